// File: rtl/isc_pkg.sv
// Shared phase encodings, direction enum and signal-head light codes for the intersection scheduler.
// ST_FLASH exists only when ISC_FLASH_MODE_EN is defined.
package isc_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_NS_G   = 3'd1,
    ST_NS_Y   = 3'd2,
    ST_EW_G   = 3'd3,
    ST_EW_Y   = 3'd4,
    ST_WALK   = 3'd5
`ifdef ISC_FLASH_MODE_EN
    , ST_FLASH = 3'd6
`endif
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  // Head is green only in its own green phase, yellow only in its own yellow phase.
  function automatic logic [2:0] head_light(input phase_e st, input phase_e grn, input phase_e yel);
    logic [2:0] l;
    l = LIGHT_RED;
    if (st == grn)      l = LIGHT_GRN;
    else if (st == yel) l = LIGHT_YEL;
    return l;
  endfunction

endpackage

// File: rtl/isc_phase_timer.sv
// Phase timer: counts cycles since the last clear; synchronous clear wins,
// and when i_sat_en is high the count holds once it reaches i_limit.
module isc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_sat_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!(i_sat_en && (r_cnt >= i_limit))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Moore sequencer sharing right-of-way between NS, EW and a pedestrian walk phase, all-red between each.
// Optional flashing-yellow mode (flash_req input, FLASH state) is built when ISC_FLASH_MODE_EN is defined.
module intersection_phase_scheduler
  import isc_pkg::*;
#(
  parameter int MIN_GREEN    = 8,
  parameter int MAX_GREEN    = 20,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 6,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       pedestrian_button,
`ifdef ISC_FLASH_MODE_EN
  input  logic       flash_req,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] current_state,
  output logic       ped_pending
);

  // Timer value on the last cycle of each phase.
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] L_AR   = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] L_WALK = CNT_W'(WALK_TIME - 1);

  phase_e     r_state;
  dir_e       r_last_dir;
  logic       r_ped_pending;
  logic       r_ped_served;
  logic [2:0] r_ns_light;
  logic [2:0] r_ew_light;
  logic       r_walk;

  phase_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic             w_clr;
  logic             w_in_green;
  logic             w_own;
  logic             w_demand;
  logic             w_green_exit;

  isc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_sat_en (w_in_green),
    .i_limit  (L_MAX),
    .o_cnt    (w_cnt)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_in_green   = (r_state == ST_NS_G) || (r_state == ST_EW_G);
    w_own        = (r_state == ST_NS_G) ? ns_req : ew_req;
    w_demand     = ((r_state == ST_NS_G) ? ew_req : ns_req) | r_ped_pending;
    w_green_exit = (w_cnt >= L_MIN) && w_demand && (!w_own || (w_cnt >= L_MAX));
    case (r_state)
      ST_ALLRED: if (w_cnt >= L_AR) begin
`ifdef ISC_FLASH_MODE_EN
        if (flash_req) w_state_nxt = ST_FLASH; else
`endif
        if (r_ped_pending && !r_ped_served) w_state_nxt = ST_WALK;
        else w_state_nxt = (r_last_dir == DIR_EW) ? ST_NS_G : ST_EW_G;
      end
      ST_NS_G: if (w_green_exit) w_state_nxt = ST_NS_Y;
      ST_NS_Y: if (w_cnt >= L_YEL) w_state_nxt = ST_ALLRED;
      ST_EW_G: if (w_green_exit) w_state_nxt = ST_EW_Y;
      ST_EW_Y: if (w_cnt >= L_YEL) w_state_nxt = ST_ALLRED;
      ST_WALK: if (w_cnt >= L_WALK) w_state_nxt = ST_ALLRED;
`ifdef ISC_FLASH_MODE_EN
      ST_FLASH: if (!flash_req) w_state_nxt = ST_ALLRED;
`endif
      default: w_state_nxt = ST_ALLRED;
    endcase
    w_clr = (w_state_nxt != r_state);
  end

`ifdef ISC_FLASH_MODE_EN
  // Flash blink phase follows the timer value the next state will start with.
  logic [CNT_W-1:0] w_cnt_nxt;
  assign w_cnt_nxt = w_clr ? '0 : (w_cnt + 1'b1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_ALLRED;
      r_last_dir    <= DIR_EW;
      r_ped_pending <= 1'b0;
      r_ped_served  <= 1'b0;
      r_ns_light    <= LIGHT_RED;
      r_ew_light    <= LIGHT_RED;
      r_walk        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_clr && (r_state == ST_NS_Y)) r_last_dir <= DIR_NS;
      else if (w_clr && (r_state == ST_EW_Y)) r_last_dir <= DIR_EW;

      if (w_clr && (r_state == ST_WALK)) r_ped_served <= 1'b1;
      else if ((r_state == ST_ALLRED) && ((w_state_nxt == ST_NS_G) || (w_state_nxt == ST_EW_G)))
        r_ped_served <= 1'b0;

      // Entering WALK clears the request even if the button is held on that edge.
      if ((r_state == ST_ALLRED) && (w_state_nxt == ST_WALK)) r_ped_pending <= 1'b0;
      else if (pedestrian_button && (r_state != ST_WALK)) r_ped_pending <= 1'b1;

      r_ns_light <= head_light(w_state_nxt, ST_NS_G, ST_NS_Y);
      r_ew_light <= head_light(w_state_nxt, ST_EW_G, ST_EW_Y);
      r_walk     <= (w_state_nxt == ST_WALK);
`ifdef ISC_FLASH_MODE_EN
      if (w_state_nxt == ST_FLASH) begin
        r_ns_light <= w_cnt_nxt[2] ? LIGHT_OFF : LIGHT_YEL;
        r_ew_light <= w_cnt_nxt[2] ? LIGHT_OFF : LIGHT_YEL;
      end
`endif
    end
  end

  assign ns_light      = r_ns_light;
  assign ew_light      = r_ew_light;
  assign walk          = r_walk;
  assign current_state = r_state;
  assign ped_pending   = r_ped_pending;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler (default build, flash mode off).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_intersection_phase_scheduler;

  localparam logic [2:0] S_AR   = 3'd0;
  localparam logic [2:0] S_NSG  = 3'd1;
  localparam logic [2:0] S_NSY  = 3'd2;
  localparam logic [2:0] S_EWG  = 3'd3;
  localparam logic [2:0] S_EWY  = 3'd4;
  localparam logic [2:0] S_WALK = 3'd5;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       ns_req;
  logic       ew_req;
  logic       pedestrian_button;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] current_state;
  logic       ped_pending;

  int n_checks = 0;
  int n_errors = 0;

  intersection_phase_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .ns_req            (ns_req),
    .ew_req            (ew_req),
    .pedestrian_button (pedestrian_button),
    .ns_light          (ns_light),
    .ew_light          (ew_light),
    .walk              (walk),
    .current_state     (current_state),
    .ped_pending       (ped_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect the given state for n consecutive cycles, advancing one cycle per sample.
  task automatic run(input string tag, input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(current_state), 32'(st));
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    ns_req = 1'b0;
    ew_req = 1'b0;
    pedestrian_button = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_state", 32'(current_state), 32'(S_AR));
    chk("rst_ns", 32'(ns_light), 32'(RED));
    chk("rst_ew", 32'(ew_light), 32'(RED));
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_ped", 32'(ped_pending), 32'd0);

    rst = 1'b0;
    run("init_allred", S_AR, 2);
    chk("init_nsg", 32'(current_state), 32'(S_NSG));
    chk("init_ns_grn", 32'(ns_light), 32'(GRN));

    // EW demand from NS_G cycle 3: min green then yellow, all-red, EW_G
    run("nsg_pre", S_NSG, 3);
    ew_req = 1'b1;
    run("nsg_min", S_NSG, 5);
    chk("nsy_ns", 32'(ns_light), 32'(YEL));
    chk("nsy_ew", 32'(ew_light), 32'(RED));
    run("nsy", S_NSY, 3);
    run("ar_to_ew", S_AR, 2);
    chk("ewg_state", 32'(current_state), 32'(S_EWG));
    chk("ewg_light", 32'(ew_light), 32'(GRN));
    chk("ewg_ns_red", 32'(ns_light), 32'(RED));

    // One-cycle pedestrian press in EW_G with no vehicle demand
    ew_req = 1'b0;
    pedestrian_button = 1'b1;
    chk("ped_pre", 32'(ped_pending), 32'd0);
    @(negedge clk);
    pedestrian_button = 1'b0;
    chk("ped_latched", 32'(ped_pending), 32'd1);
    run("ewg_ped", S_EWG, 7);
    run("ewy", S_EWY, 3);
    run("ar_to_walk", S_AR, 2);
    chk("walk_lamp", 32'(walk), 32'd1);
    chk("walk_ns", 32'(ns_light), 32'(RED));
    chk("walk_ew", 32'(ew_light), 32'(RED));
    chk("walk_ped_clr", 32'(ped_pending), 32'd0);
    run("walk_a", S_WALK, 2);
    pedestrian_button = 1'b1;
    run("walk_b", S_WALK, 1);
    pedestrian_button = 1'b0;
    run("walk_c", S_WALK, 3);
    chk("walk_press_ignored", 32'(ped_pending), 32'd0);
    chk("post_walk_lamp", 32'(walk), 32'd0);
    run("ar_after_walk", S_AR, 2);
    chk("nsg_after_walk", 32'(current_state), 32'(S_NSG));

    // Both detectors held: green runs to max
    ns_req = 1'b1;
    ew_req = 1'b1;
    run("nsg_max", S_NSG, 20);
    run("nsy_max", S_NSY, 3);
    run("ar_max", S_AR, 2);
    chk("ewg_after_max", 32'(current_state), 32'(S_EWG));

    // Press exactly on the ALLRED->WALK edge
    ns_req = 1'b0;
    ew_req = 1'b0;
    pedestrian_button = 1'b1;
    @(negedge clk);
    pedestrian_button = 1'b0;
    chk("ped2_latched", 32'(ped_pending), 32'd1);
    run("ewg2", S_EWG, 7);
    run("ewy2", S_EWY, 3);
    run("ar2_a", S_AR, 1);
    pedestrian_button = 1'b1;
    run("ar2_b", S_AR, 1);
    pedestrian_button = 1'b0;
    chk("edge_press_clr", 32'(ped_pending), 32'd0);
    run("walk2", S_WALK, 6);
    run("ar2_after", S_AR, 2);
    chk("no_second_walk", 32'(current_state), 32'(S_NSG));
    chk("ped2_final", 32'(ped_pending), 32'd0);

    // No demand: NS_G rests
    for (int i = 0; i < 60; i++) begin
      chk("rest_nsg", 32'(current_state), 32'(S_NSG));
      chk("rest_ew_red", 32'(ew_light), 32'(RED));
      @(negedge clk);
    end

    // Asynchronous reset mid-phase with a pending request
    pedestrian_button = 1'b1;
    @(negedge clk);
    pedestrian_button = 1'b0;
    chk("pre_rst_ped", 32'(ped_pending), 32'd1);
    chk("pre_rst_state", 32'(current_state), 32'(S_NSG));
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(current_state), 32'(S_AR));
    chk("arst_ns", 32'(ns_light), 32'(RED));
    chk("arst_ew", 32'(ew_light), 32'(RED));
    chk("arst_walk", 32'(walk), 32'd0);
    chk("arst_ped", 32'(ped_pending), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run("rerun_allred", S_AR, 2);
    chk("rerun_nsg", 32'(current_state), 32'(S_NSG));
    chk("rerun_ns_grn", 32'(ns_light), 32'(GRN));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
